// File: rtl/typing_pkg.sv
// Shared encodings and constants for the typing-test controller and its divider.
package typing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_WORD      = 3'd2,
    ST_BLANK     = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_SPACE = 9'h029;

  // Divisor is 10 bits so the accuracy denominator (up to 511 + 255) fits.
  localparam int DVD_W = 16;
  localparam int DVS_W = 10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/typing_test_ctrl_if.sv
// Keyboard, text-ROM and result signals between the typing controller and its surroundings.
interface typing_test_ctrl_if #(
  parameter int IDX_W = 8,
  parameter int WPM_W = 7
);
  logic [511:0]      key_down;
  logic [8:0]        last_change;
  logic              been_ready;
  logic [8:0]        exp_code;
  logic              exp_space;
  logic              exp_last;
  logic [IDX_W-1:0]  char_idx;
  logic [2:0]        state;
  logic [7:0]        secs;
  logic [7:0]        word_cnt;
  logic [7:0]        err_cnt;
  logic [WPM_W-1:0]  wpm;
  logic [WPM_W-1:0]  acc_pct;
  logic              result_vld;

  modport master (
    output key_down, last_change, been_ready, exp_code, exp_space, exp_last,
    input  char_idx, state, secs, word_cnt, err_cnt, wpm, acc_pct, result_vld
  );

  modport slave (
    input  key_down, last_change, been_ready, exp_code, exp_space, exp_last,
    output char_idx, state, secs, word_cnt, err_cnt, wpm, acc_pct, result_vld
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is resolved on the start edge.
module seq_divider
  import typing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);
  logic [DVS_W-1:0] rem_reg, rem_next;
  logic [DVD_W-1:0] quo_reg, quo_next, quo_src;
  logic [DVS_W:0]   partial, diff;
  logic             fits;
  logic [4:0]       cnt_reg;
  logic             busy_reg, done_reg;

  always_comb begin
    quo_src  = start ? dividend : quo_reg;
    partial  = start ? {{DVS_W{1'b0}}, dividend[DVD_W-1]} : {rem_reg, quo_reg[DVD_W-1]};
    diff     = partial - {1'b0, divisor};
    fits     = (partial >= {1'b0, divisor});
    rem_next = fits ? diff[DVS_W-1:0] : partial[DVS_W-1:0];
    quo_next = {quo_src[DVD_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        cnt_reg  <= 5'(DVD_W - 1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = quo_reg;
endmodule

// File: rtl/typing_test_ctrl.sv
// Typing-test game FSM: countdown, word/blank typing, WPM result via shared divider.
// Define ACCURACY_EN to also compute accuracy percentage with a second division.
module typing_test_ctrl
  import typing_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int START_SECS = 3,
  parameter int TEST_SECS  = 60,
  parameter int IDX_W      = 8,
  parameter int WPM_W      = 7
) (
  input logic               clk,
  input logic               rst,
  typing_test_ctrl_if.slave bus
);
  localparam int                TICK_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_HZ - 1);
  localparam logic [WPM_W-1:0]  WPM_MAX  = '1;

  state_t             state_reg;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [IDX_W-1:0]   char_idx_reg;
  logic [7:0]         secs_reg, word_cnt_reg, err_cnt_reg;
  logic [WPM_W-1:0]   wpm_reg;
  logic               result_vld_reg, div_start_reg;

  logic press, esc_press, enter_press, tick, typing, correct, wrong, time_up, finish_now;
  logic             div_busy, div_done;
  logic [DVD_W-1:0] div_dividend, div_quotient;
  logic [DVS_W-1:0] div_divisor;

`ifdef ACCURACY_EN
  logic [8:0]       correct_cnt_reg;
  logic             acc_phase_reg;
  logic [WPM_W-1:0] acc_pct_reg;
  logic [DVS_W-1:0] acc_den;
`endif

  function automatic logic [WPM_W-1:0] sat_q(input logic [DVD_W-1:0] q);
    return (q > DVD_W'(WPM_MAX)) ? WPM_MAX : q[WPM_W-1:0];
  endfunction

  always_comb begin
    press       = bus.been_ready & bus.key_down[bus.last_change];
    esc_press   = press && (bus.last_change == KEY_ESC);
    enter_press = press && (bus.last_change == KEY_ENTER);
    tick        = (tick_cnt_reg == TICK_MAX);
    typing      = (state_reg == ST_WORD) || (state_reg == ST_BLANK);
    correct     = typing && press && !esc_press && (bus.last_change == bus.exp_code);
    wrong       = typing && press && !esc_press && (bus.last_change != bus.exp_code);
    time_up     = typing && tick && (secs_reg == 8'(TEST_SECS - 1));
    finish_now  = (correct && bus.exp_last) || time_up;
  end

  always_comb begin
    div_dividend = DVD_W'(word_cnt_reg) * DVD_W'(60);
    div_divisor  = (secs_reg == 8'd0) ? DVS_W'(1) : DVS_W'(secs_reg);
`ifdef ACCURACY_EN
    acc_den = DVS_W'(correct_cnt_reg) + DVS_W'(err_cnt_reg);
    if (acc_phase_reg) begin
      div_dividend = DVD_W'(correct_cnt_reg) * DVD_W'(100);
      div_divisor  = (acc_den == '0) ? DVS_W'(1) : acc_den;
    end
`endif
  end

  // WORD and BLANK form one timed phase: the second counter keeps running across them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      tick_cnt_reg   <= '0;
      char_idx_reg   <= '0;
      secs_reg       <= '0;
      word_cnt_reg   <= '0;
      err_cnt_reg    <= '0;
      wpm_reg        <= '0;
      result_vld_reg <= 1'b0;
      div_start_reg  <= 1'b0;
`ifdef ACCURACY_EN
      correct_cnt_reg <= '0;
      acc_phase_reg   <= 1'b0;
      acc_pct_reg     <= '0;
`endif
    end else begin
      div_start_reg <= 1'b0;
      if (state_reg == ST_COUNTDOWN || typing)
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
      else
        tick_cnt_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (enter_press) begin
            state_reg    <= ST_COUNTDOWN;
            secs_reg     <= 8'(START_SECS);
            char_idx_reg <= '0;
            word_cnt_reg <= '0;
            err_cnt_reg  <= '0;
`ifdef ACCURACY_EN
            correct_cnt_reg <= '0;
`endif
          end
        end
        ST_COUNTDOWN: begin
          if (esc_press) begin
            state_reg <= ST_IDLE;
          end else if (tick) begin
            if (secs_reg == 8'd1) begin
              state_reg <= bus.exp_space ? ST_BLANK : ST_WORD;
              secs_reg  <= 8'd0;
            end else begin
              secs_reg <= secs_reg - 8'd1;
            end
          end
        end
        ST_WORD, ST_BLANK: begin
          if (esc_press) begin
            state_reg <= ST_IDLE;
          end else begin
            if (tick)
              secs_reg <= secs_reg + 8'd1;
            if (correct) begin
              char_idx_reg <= (char_idx_reg == '1) ? char_idx_reg : char_idx_reg + IDX_W'(1);
              if (bus.exp_space || bus.exp_last)
                word_cnt_reg <= sat_inc8(word_cnt_reg);
`ifdef ACCURACY_EN
              correct_cnt_reg <= (correct_cnt_reg == '1) ? correct_cnt_reg : correct_cnt_reg + 9'd1;
`endif
            end
            if (wrong)
              err_cnt_reg <= sat_inc8(err_cnt_reg);
            if (finish_now) begin
              state_reg     <= ST_FINISH;
              div_start_reg <= 1'b1;
`ifdef ACCURACY_EN
              acc_phase_reg <= 1'b0;
`endif
            end else begin
              state_reg <= bus.exp_space ? ST_BLANK : ST_WORD;
            end
          end
        end
        ST_FINISH: begin
          if (result_vld_reg) begin
            if (enter_press) begin
              state_reg      <= ST_IDLE;
              result_vld_reg <= 1'b0;
            end
          end else if (div_done && !div_busy) begin
`ifdef ACCURACY_EN
            if (!acc_phase_reg) begin
              wpm_reg       <= sat_q(div_quotient);
              acc_phase_reg <= 1'b1;
              div_start_reg <= 1'b1;
            end else begin
              acc_pct_reg    <= sat_q(div_quotient);
              result_vld_reg <= 1'b1;
            end
`else
            wpm_reg        <= sat_q(div_quotient);
            result_vld_reg <= 1'b1;
`endif
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_reg),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign bus.state      = state_reg;
  assign bus.char_idx   = char_idx_reg;
  assign bus.secs       = secs_reg;
  assign bus.word_cnt   = word_cnt_reg;
  assign bus.err_cnt    = err_cnt_reg;
  assign bus.wpm        = wpm_reg;
  assign bus.result_vld = result_vld_reg;
`ifdef ACCURACY_EN
  assign bus.acc_pct = acc_pct_reg;
`else
  assign bus.acc_pct = '0;
`endif
endmodule

// File: tb/tb_typing_test_ctrl.sv
// Self-checking bench for typing_test_ctrl: directed scenarios plus randomized typing sessions.
module tb_typing_test_ctrl;
  import typing_pkg::*;

  localparam int CLK_HZ = 10, START_SECS = 3, TEST_SECS = 60, IDX_W = 8, WPM_W = 7;
`ifdef ACCURACY_EN
  localparam bit ACC_ON  = 1'b1;
  localparam int RES_LAT = 34;
`else
  localparam bit ACC_ON  = 1'b0;
  localparam int RES_LAT = 17;
`endif
  localparam logic [8:0] K_A = 9'h01C, K_B = 9'h032, K_C = 9'h021, K_D = 9'h023, K_E = 9'h024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   text_len = 1;
  logic [8:0] text_mem [0:255];
  logic [8:0] letters  [0:4];

  typing_test_ctrl_if #(.IDX_W(IDX_W), .WPM_W(WPM_W)) bus();

  typing_test_ctrl #(
    .CLK_HZ(CLK_HZ), .START_SECS(START_SECS), .TEST_SECS(TEST_SECS), .IDX_W(IDX_W), .WPM_W(WPM_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Text ROM: combinational lookup at the current character index.
  always_comb begin
    bus.exp_code  = text_mem[bus.char_idx];
    bus.exp_space = (text_mem[bus.char_idx] == KEY_SPACE);
    bus.exp_last  = (int'(bus.char_idx) == text_len - 1);
  end

  function automatic int model_wpm(input int words, input int s);
    int q;
    q = (words * 60) / ((s == 0) ? 1 : s);
    return (q > 127) ? 127 : q;
  endfunction

  function automatic int model_acc(input int c, input int e);
    if (!ACC_ON) return 0;
    return (c * 100) / (((c + e) == 0) ? 1 : (c + e));
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [8:0] code, input logic make);
    bus.last_change    = code;
    bus.key_down[code] = make;
    bus.been_ready     = 1'b1;
    @(negedge clk);
    bus.been_ready     = 1'b0;
    bus.key_down[code] = 1'b0;
    $display("key code=%h make=%0d cyc=%0d idx=%0d state=%0d err=%0d", code, make, cyc,
             bus.char_idx, bus.state, bus.err_cnt);
  endtask

  task automatic set_text_ab_c();
    text_mem[0] = K_A; text_mem[1] = K_B; text_mem[2] = KEY_SPACE; text_mem[3] = K_C;
    text_len = 4;
  endtask

  task automatic begin_typing(output int t0);
    press_key(KEY_ENTER, 1'b1);
    t0 = cyc + 30;
    tick_n(30);
  endtask

  task automatic wait_result(input int fin_cyc, output int lat);
    while (!bus.result_vld && (cyc - fin_cyc) < 60) tick_n(1);
    lat = cyc - fin_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick_n(3);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", bus.state); end
    total++; if (bus.secs !== 8'd0) begin bad++; $display("FAIL rst_secs got=%0d want=0", bus.secs); end
    total++; if (bus.char_idx !== 8'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", bus.char_idx); end
    total++; if (bus.word_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin bad++;
      $display("FAIL rst_cnts got=%0d/%0d want=0/0", bus.word_cnt, bus.err_cnt); end
    total++; if (bus.wpm !== 7'd0 || bus.acc_pct !== 7'd0 || bus.result_vld !== 1'b0) begin bad++;
      $display("FAIL rst_result got=%0d/%0d/%0d want=0/0/0", bus.wpm, bus.acc_pct, bus.result_vld); end
    rst = 1'b1;
    tick_n(2);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", bus.state); end
  endtask

  task automatic test_countdown();
    set_text_ab_c();
    press_key(KEY_ENTER, 1'b1);
    total++; if (bus.state !== 3'd1 || bus.secs !== 8'd3) begin bad++;
      $display("FAIL cd_enter got=%0d/%0d want=1/3", bus.state, bus.secs); end
    tick_n(9);
    total++; if (bus.secs !== 8'd3) begin bad++; $display("FAIL cd_pre_tick got=%0d want=3", bus.secs); end
    tick_n(1);
    total++; if (bus.secs !== 8'd2) begin bad++; $display("FAIL cd_secs2 got=%0d want=2", bus.secs); end
    tick_n(10);
    total++; if (bus.secs !== 8'd1) begin bad++; $display("FAIL cd_secs1 got=%0d want=1", bus.secs); end
    tick_n(9);
    total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL cd_hold got=%0d want=1", bus.state); end
    tick_n(1);
    total++; if (bus.state !== 3'd2 || bus.secs !== 8'd0) begin bad++;
      $display("FAIL cd_to_word got=%0d/%0d want=2/0", bus.state, bus.secs); end
    press_key(KEY_ESC, 1'b1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL esc_word got=%0d want=0", bus.state); end
  endtask

  task automatic test_word_entry();
    int t0, fin_cyc, lat;
    set_text_ab_c();
    begin_typing(t0);
    press_key(K_D, 1'b1);
    total++; if (bus.err_cnt !== 8'd1 || bus.char_idx !== 8'd0) begin bad++;
      $display("FAIL we_wrong got=%0d/%0d want=1/0", bus.err_cnt, bus.char_idx); end
    tick_n(t0 + 50 - cyc);
    press_key(K_A, 1'b1); press_key(K_B, 1'b1); press_key(KEY_SPACE, 1'b1); press_key(K_C, 1'b1);
    fin_cyc = cyc;
    total++; if (bus.state !== 3'd4 || bus.word_cnt !== 8'd2 || bus.char_idx !== 8'd4 || bus.secs !== 8'd5) begin bad++;
      $display("FAIL we_finish got=%0d/%0d/%0d/%0d want=4/2/4/5", bus.state, bus.word_cnt, bus.char_idx, bus.secs); end
    press_key(KEY_ENTER, 1'b1);
    total++; if (bus.state !== 3'd4 || bus.result_vld !== 1'b0) begin bad++;
      $display("FAIL we_key_ignored got=%0d/%0d want=4/0", bus.state, bus.result_vld); end
    wait_result(fin_cyc, lat);
    total++; if (lat != RES_LAT) begin bad++; $display("FAIL we_latency got=%0d want=%0d", lat, RES_LAT); end
    total++; if (int'(bus.wpm) != 24) begin bad++; $display("FAIL we_wpm got=%0d want=24", bus.wpm); end
    total++; if (int'(bus.acc_pct) != model_acc(4, 1)) begin bad++;
      $display("FAIL we_acc got=%0d want=%0d", bus.acc_pct, model_acc(4, 1)); end
    press_key(KEY_ENTER, 1'b1);
    total++; if (bus.state !== 3'd0 || bus.result_vld !== 1'b0) begin bad++;
      $display("FAIL we_back_idle got=%0d/%0d want=0/0", bus.state, bus.result_vld); end
  endtask

  task automatic test_errors();
    int t0;
    set_text_ab_c();
    begin_typing(t0);
    press_key(K_B, 1'b1);
    total++; if (bus.err_cnt !== 8'd1 || bus.char_idx !== 8'd0) begin bad++;
      $display("FAIL err_first got=%0d/%0d want=1/0", bus.err_cnt, bus.char_idx); end
    for (int i = 0; i < 299; i++) press_key(letters[$urandom_range(1, 4)], 1'b1);
    total++; if (bus.err_cnt !== 8'd255 || bus.char_idx !== 8'd0) begin bad++;
      $display("FAIL err_sat got=%0d/%0d want=255/0", bus.err_cnt, bus.char_idx); end
    total++; if (int'(bus.secs) != (cyc - t0) / CLK_HZ) begin bad++;
      $display("FAIL err_secs got=%0d want=%0d", bus.secs, (cyc - t0) / CLK_HZ); end
    press_key(KEY_ESC, 1'b1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL err_esc got=%0d want=0", bus.state); end
  endtask

  task automatic test_timeout();
    int t0, fin_cyc, lat;
    set_text_ab_c();
    begin_typing(t0);
    tick_n(599);
    total++; if (bus.state !== 3'd2 || bus.secs !== 8'd59) begin bad++;
      $display("FAIL to_pre got=%0d/%0d want=2/59", bus.state, bus.secs); end
    tick_n(1);
    fin_cyc = cyc;
    total++; if (bus.state !== 3'd4 || bus.secs !== 8'd60 || bus.word_cnt !== 8'd0) begin bad++;
      $display("FAIL to_finish got=%0d/%0d/%0d want=4/60/0", bus.state, bus.secs, bus.word_cnt); end
    wait_result(fin_cyc, lat);
    total++; if (lat != RES_LAT || bus.wpm !== 7'd0 || bus.acc_pct !== 7'd0) begin bad++;
      $display("FAIL to_result got=%0d/%0d/%0d want=%0d/0/0", lat, bus.wpm, bus.acc_pct, RES_LAT); end
    press_key(KEY_ENTER, 1'b1);
    total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL to_idle got=%0d want=0", bus.state); end
  endtask

  task automatic test_reset_mid_div();
    int t0;
    set_text_ab_c();
    begin_typing(t0);
    tick_n(20);
    press_key(K_A, 1'b1); press_key(K_B, 1'b1); press_key(KEY_SPACE, 1'b1); press_key(K_C, 1'b1);
    tick_n(5);
    rst = 1'b0;
    tick_n(1);
    total++; if (bus.state !== 3'd0 || bus.result_vld !== 1'b0 || bus.word_cnt !== 8'd0) begin bad++;
      $display("FAIL mid_rst got=%0d/%0d/%0d want=0/0/0", bus.state, bus.result_vld, bus.word_cnt); end
    rst = 1'b1;
    tick_n(RES_LAT + 5);
    total++; if (bus.state !== 3'd0 || bus.result_vld !== 1'b0 || bus.wpm !== 7'd0) begin bad++;
      $display("FAIL mid_rst_after got=%0d/%0d/%0d want=0/0/0", bus.state, bus.result_vld, bus.wpm); end
  endtask

  task automatic test_random(input int iters);
    int t0, idx, w, e, c, act, fin_cyc, lat, s, want_state;
    logic [8:0] code;
    bit done;
    for (int it = 0; it < iters; it++) begin
      text_len = $urandom_range(4, 12);
      for (int i = 0; i < text_len; i++)
        text_mem[i] = ($urandom_range(0, 3) == 0) ? KEY_SPACE : letters[$urandom_range(0, 4)];
      text_mem[text_len - 1] = letters[$urandom_range(0, 4)];
      begin_typing(t0);
      want_state = (text_mem[0] == KEY_SPACE) ? 3 : 2;
      total++; if (int'(bus.state) != want_state) begin bad++;
        $display("FAIL rnd_start got=%0d want=%0d", bus.state, want_state); end
      idx = 0; w = 0; e = 0; c = 0; done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
        act = $urandom_range(0, 9);
        if (act <= 5) begin
          press_key(text_mem[idx], 1'b1);
          c++;
          if (text_mem[idx] == KEY_SPACE || idx == text_len - 1) w++;
          if (idx == text_len - 1) done = 1'b1;
          idx++;
        end else if (act <= 7) begin
          code = letters[$urandom_range(0, 4)];
          while (code == text_mem[idx]) code = letters[$urandom_range(0, 4)];
          press_key(code, 1'b1);
          if (e < 255) e++;
        end else begin
          press_key(text_mem[idx], 1'b0);
        end
        if (!done) begin
          tick_n($urandom_range(1, 3));
          want_state = (text_mem[idx] == KEY_SPACE) ? 3 : 2;
          total++;
          if (int'(bus.char_idx) != idx || int'(bus.err_cnt) != e || int'(bus.word_cnt) != w ||
              int'(bus.state) != want_state || int'(bus.secs) != (cyc - t0) / CLK_HZ) begin
            bad++;
            $display("FAIL rnd_step got=idx%0d err%0d w%0d st%0d s%0d want=idx%0d err%0d w%0d st%0d s%0d",
                     bus.char_idx, bus.err_cnt, bus.word_cnt, bus.state, bus.secs,
                     idx, e, w, want_state, (cyc - t0) / CLK_HZ);
          end
        end
      end
      total++; if (!done) begin bad++; $display("FAIL rnd_budget got=unfinished want=finished"); end
      fin_cyc = cyc;
      s = (fin_cyc - t0) / CLK_HZ;
      total++; if (bus.state !== 3'd4 || int'(bus.word_cnt) != w || int'(bus.secs) != s) begin bad++;
        $display("FAIL rnd_finish got=%0d/%0d/%0d want=4/%0d/%0d", bus.state, bus.word_cnt, bus.secs, w, s); end
      wait_result(fin_cyc, lat);
      total++; if (lat != RES_LAT) begin bad++; $display("FAIL rnd_latency got=%0d want=%0d", lat, RES_LAT); end
      total++; if (int'(bus.wpm) != model_wpm(w, s) || int'(bus.acc_pct) != model_acc(c, e)) begin bad++;
        $display("FAIL rnd_result got=%0d/%0d want=%0d/%0d", bus.wpm, bus.acc_pct, model_wpm(w, s), model_acc(c, e)); end
      press_key(KEY_ENTER, 1'b1);
      total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rnd_idle got=%0d want=0", bus.state); end
    end
  endtask

  initial begin
    bus.key_down    = '0;
    bus.last_change = '0;
    bus.been_ready  = 1'b0;
    for (int i = 0; i < 256; i++) text_mem[i] = '0;
    letters[0] = K_A; letters[1] = K_B; letters[2] = K_C; letters[3] = K_D; letters[4] = K_E;
    test_reset();
    test_countdown();
    test_word_entry();
    test_errors();
    test_timeout();
    test_reset_mid_div();
    test_random(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
